// File: rtl/change_dispenser_if.sv
// Coin-return bus: payout request, tube refill, ejector pulses and status between controller and its host.
// Ports are grouped so that the host drives the master side and the dispenser sits on the slave side.
interface change_dispenser_if #(
  parameter int AMT_W  = 9,
  parameter int TUBE_W = 5
);
  logic              start;
  logic [AMT_W-1:0]  amount;
  logic              load;
  logic [TUBE_W-1:0] load_q;
  logic [TUBE_W-1:0] load_d;
  logic [TUBE_W-1:0] load_n;
  logic              busy;
  logic              done;
  logic              short;
  logic [AMT_W-1:0]  remaining;
  logic              eject_q;
  logic              eject_d;
  logic              eject_n;
  logic [TUBE_W-1:0] quart;
  logic [TUBE_W-1:0] dim;
  logic [TUBE_W-1:0] nick;

  modport master (
    output start, amount, load, load_q, load_d, load_n,
    input  busy, done, short, remaining, eject_q, eject_d, eject_n, quart, dim, nick
  );

  modport slave (
    input  start, amount, load, load_q, load_d, load_n,
    output busy, done, short, remaining, eject_q, eject_d, eject_n, quart, dim, nick
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy quarter/dime/nickel payout: one coin per (2 + GAP_CYCLES)-cycle slot, done one cycle after the last SELECT.
// No backpressure: start/load are only honoured in IDLE and are dropped, not queued, while busy.
module change_dispenser #(
  parameter int AMT_W      = 9,
  parameter int TUBE_W     = 5,
  parameter int TUBE_MAX   = 20,
  parameter int GAP_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_EJECT, ST_GAP} state_t;
  typedef enum logic [1:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N} coin_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            state_q, state_d;
  coin_t             coin_q, coin_d;
  logic [AMT_W-1:0]  remaining_q, remaining_d;
  logic              short_q, short_d;
  logic              done_q, done_d;
  logic [TUBE_W-1:0] quart_q, quart_d;
  logic [TUBE_W-1:0] dim_q, dim_d;
  logic [TUBE_W-1:0] nick_q, nick_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  function automatic logic [TUBE_W-1:0] clamp(input logic [TUBE_W-1:0] v);
    return (v > TUBE_W'(TUBE_MAX)) ? TUBE_W'(TUBE_MAX) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      coin_q      <= COIN_NONE;
      remaining_q <= '0;
      short_q     <= 1'b0;
      done_q      <= 1'b0;
      quart_q     <= '0;
      dim_q       <= '0;
      nick_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      short_q     <= short_d;
      done_q      <= done_d;
      quart_q     <= quart_d;
      dim_q       <= dim_d;
      nick_q      <= nick_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    short_d     = short_q;
    done_d      = 1'b0;
    quart_d     = quart_q;
    dim_d       = dim_q;
    nick_d      = nick_q;
    gap_d       = gap_q;
    case (state_q)
      ST_IDLE: begin
        // Load lands on the same edge as start, so SELECT sees the refilled tubes.
        if (bus.load) begin
          quart_d = clamp(bus.load_q);
          dim_d   = clamp(bus.load_d);
          nick_d  = clamp(bus.load_n);
        end
        if (bus.start) begin
          remaining_d = bus.amount;
          short_d     = 1'b0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_q >= AMT_W'(25) && quart_q != '0) begin
          coin_d      = COIN_Q;
          quart_d     = quart_q - TUBE_W'(1);
          remaining_d = remaining_q - AMT_W'(25);
          state_d     = ST_EJECT;
        end else if (remaining_q >= AMT_W'(10) && dim_q != '0) begin
          coin_d      = COIN_D;
          dim_d       = dim_q - TUBE_W'(1);
          remaining_d = remaining_q - AMT_W'(10);
          state_d     = ST_EJECT;
        end else if (remaining_q >= AMT_W'(5) && nick_q != '0) begin
          coin_d      = COIN_N;
          nick_d      = nick_q - TUBE_W'(1);
          remaining_d = remaining_q - AMT_W'(5);
          state_d     = ST_EJECT;
        end else begin
          coin_d  = COIN_NONE;
          done_d  = 1'b1;
          short_d = (remaining_q != '0);
          state_d = ST_IDLE;
        end
      end
      ST_EJECT: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_SELECT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = done_q;
    bus.short     = short_q;
    bus.remaining = remaining_q;
    bus.eject_q   = (state_q == ST_EJECT) && (coin_q == COIN_Q);
    bus.eject_d   = (state_q == ST_EJECT) && (coin_q == COIN_D);
    bus.eject_n   = (state_q == ST_EJECT) && (coin_q == COIN_N);
    bus.quart     = quart_q;
    bus.dim       = dim_q;
    bus.nick      = nick_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a slot-schedule model predicts every output each cycle,
// and directed payouts are pinned with hand-computed eject sequences, timings and tube counts.
module tb_change_dispenser;
  localparam int GAP = 1;
  localparam int P   = 2 + GAP;

  logic clk;
  logic rst;
  change_dispenser_if #(.AMT_W(9), .TUBE_W(5)) bus ();

  change_dispenser #(.AMT_W(9), .TUBE_W(5), .TUBE_MAX(20), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int e0          = 0;
  bit cmp_en      = 1'b0;

  // Model state: tubes, remaining, and a precomputed list of coins paid out by slot.
  logic       m_busy, m_done, m_short;
  logic [8:0] m_rem;
  logic [4:0] m_q, m_d, m_n;
  logic [2:0] m_ej;
  logic [8:0] coins[$];
  int         m_k;

  function automatic logic [4:0] mclamp(input logic [4:0] v);
    return (v > 5'd20) ? 5'd20 : v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    m_ej   = 3'b000;
    if (rst) begin
      m_busy = 1'b0; m_short = 1'b0; m_rem = '0;
      m_q = '0; m_d = '0; m_n = '0;
      coins.delete();
    end else if (!m_busy) begin
      if (bus.load) begin
        m_q = mclamp(bus.load_q); m_d = mclamp(bus.load_d); m_n = mclamp(bus.load_n);
      end
      if (bus.start) begin
        logic [8:0] r;
        logic [4:0] tq, td, tn;
        r = bus.amount; tq = m_q; td = m_d; tn = m_n;
        coins.delete();
        for (int g = 0; g < 64; g++) begin
          if (r >= 9'd25 && tq != 0) begin coins.push_back(9'd25); r = r - 9'd25; tq = tq - 5'd1; end
          else if (r >= 9'd10 && td != 0) begin coins.push_back(9'd10); r = r - 9'd10; td = td - 5'd1; end
          else if (r >= 9'd5 && tn != 0) begin coins.push_back(9'd5); r = r - 9'd5; tn = tn - 5'd1; end
          else break;
        end
        m_rem = bus.amount; m_short = 1'b0; m_busy = 1'b1; m_k = 0;
      end
    end else begin
      m_k++;
      if (m_k == coins.size() * P + 1) begin
        m_busy = 1'b0; m_done = 1'b1; m_short = (m_rem != 0);
      end else if ((m_k - 1) % P == 0) begin
        logic [8:0] c;
        c = coins[(m_k - 1) / P];
        m_rem = m_rem - c;
        if (c == 9'd25) begin m_q = m_q - 5'd1; m_ej = 3'b100; end
        else if (c == 9'd10) begin m_d = m_d - 5'd1; m_ej = 3'b010; end
        else begin m_n = m_n - 5'd1; m_ej = 3'b001; end
      end
    end
  end

  string ej_str;
  int    ej_t[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (bus.busy !== m_busy || bus.done !== m_done || bus.short !== m_short ||
          {bus.eject_q, bus.eject_d, bus.eject_n} !== m_ej || bus.remaining !== m_rem ||
          bus.quart !== m_q || bus.dim !== m_d || bus.nick !== m_n) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: dut busy=%b done=%b short=%b ej=%b rem=%0d tubes=%0d/%0d/%0d, model busy=%b done=%b short=%b ej=%b rem=%0d tubes=%0d/%0d/%0d",
                 cyc, bus.busy, bus.done, bus.short, {bus.eject_q, bus.eject_d, bus.eject_n},
                 bus.remaining, bus.quart, bus.dim, bus.nick,
                 m_busy, m_done, m_short, m_ej, m_rem, m_q, m_d, m_n);
      end
    end
    if (bus.eject_q) begin ej_str = {ej_str, "q"}; ej_t.push_back(cyc - e0); end
    if (bus.eject_d) begin ej_str = {ej_str, "d"}; ej_t.push_back(cyc - e0); end
    if (bus.eject_n) begin ej_str = {ej_str, "n"}; ej_t.push_back(cyc - e0); end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic chk_tubes(input string name, input int q, input int d, input int n);
    chk({name, " quart"}, int'(bus.quart), q);
    chk({name, " dim"},   int'(bus.dim),   d);
    chk({name, " nick"},  int'(bus.nick),  n);
  endtask

  int done_t;

  // Runs one payout; optionally reloads with start and injects an ignored start/load mid-payout.
  task automatic pay(input int amt, input bit ld, input int lq, input int ldd, input int ln, input int mid);
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.amount = 9'(amt);
    bus.load = ld; bus.load_q = 5'(lq); bus.load_d = 5'(ldd); bus.load_n = 5'(ln);
    e0 = cyc + 1; ej_str = ""; ej_t.delete();
    @(negedge clk);
    bus.start = 1'b0; bus.load = 1'b0;
    got = 1'b0; done_t = -1;
    for (int i = 0; i < 300; i++) begin
      if (mid > 0 && i == mid) begin
        bus.start = 1'b1; bus.amount = 9'd25;
        bus.load = 1'b1; bus.load_q = 5'd9; bus.load_d = 5'd9; bus.load_n = 5'd9;
      end else if (mid > 0 && i == mid + 1) begin
        bus.start = 1'b0; bus.load = 1'b0;
      end
      if (bus.done) begin got = 1'b1; done_t = cyc - e0; break; end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.load = 1'b0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL done timeout for amount %0d: got no done, expected one within 300 cycles", amt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.amount = '0; bus.load = 1'b0;
    bus.load_q = '0; bus.load_d = '0; bus.load_n = '0;
    ej_str = "";
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset remaining", int'(bus.remaining), 0);
    chk_tubes("reset", 0, 0, 0);
    rst = 1'b0;

    // Load clamps to tube capacity.
    @(negedge clk);
    bus.load = 1'b1; bus.load_q = 5'd31; bus.load_d = 5'd20; bus.load_n = 5'd21;
    @(negedge clk);
    bus.load = 1'b0;
    chk_tubes("clamp", 20, 20, 20);

    pay(40, 1'b1, 4, 4, 4, 0);
    chk_s("t1 ejects", ej_str, "qdn");
    chk("t1 q time", (ej_t.size() > 0) ? ej_t[0] : -1, 1);
    chk("t1 d time", (ej_t.size() > 1) ? ej_t[1] : -1, 4);
    chk("t1 n time", (ej_t.size() > 2) ? ej_t[2] : -1, 7);
    chk("t1 done time", done_t, 10);
    chk("t1 busy at done", int'(bus.busy), 0);
    chk("t1 short", int'(bus.short), 0);
    chk("t1 remaining", int'(bus.remaining), 0);
    chk_tubes("t1", 3, 3, 3);
    chk("t1 model quart", int'(m_q), 3);

    pay(75, 1'b1, 1, 4, 4, 0);
    chk_s("t2 ejects", ej_str, "qddddnn");
    chk("t2 done time", done_t, 22);
    chk("t2 short", int'(bus.short), 0);
    chk_tubes("t2", 0, 0, 2);

    pay(15, 1'b1, 0, 0, 1, 0);
    chk_s("t3 ejects", ej_str, "n");
    chk("t3 done time", done_t, 4);
    chk("t3 short", int'(bus.short), 1);
    chk("t3 remaining", int'(bus.remaining), 10);
    chk("t3 model remaining", int'(m_rem), 10);

    pay(0, 1'b0, 0, 0, 0, 0);
    chk_s("t4 ejects", ej_str, "");
    chk("t4 done time", done_t, 1);
    chk("t4 short", int'(bus.short), 0);

    pay(7, 1'b1, 4, 4, 4, 0);
    chk_s("t5 ejects", ej_str, "n");
    chk("t5 short", int'(bus.short), 1);
    chk("t5 remaining", int'(bus.remaining), 2);
    chk_tubes("t5", 4, 4, 3);

    pay(40, 1'b1, 4, 4, 4, 3);
    chk_s("t6 ejects", ej_str, "qdn");
    chk("t6 done time", done_t, 10);
    chk("t6 remaining", int'(bus.remaining), 0);
    chk_tubes("t6", 3, 3, 3);

    pay(20, 1'b1, 0, 2, 0, 0);
    chk_s("t7 ejects", ej_str, "dd");
    chk("t7 short", int'(bus.short), 0);
    chk_tubes("t7", 0, 0, 0);

    // Reset lands while the first ejector pulse is on the bus.
    @(negedge clk);
    bus.start = 1'b1; bus.amount = 9'd40;
    bus.load = 1'b1; bus.load_q = 5'd4; bus.load_d = 5'd4; bus.load_n = 5'd4;
    e0 = cyc + 1; ej_str = ""; ej_t.delete();
    @(negedge clk);
    bus.start = 1'b0; bus.load = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.eject_q || bus.eject_d || bus.eject_n) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      chk("rst eject seen", int'(seen), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst eject", int'({bus.eject_q, bus.eject_d, bus.eject_n}), 0);
    chk("rst remaining", int'(bus.remaining), 0);
    chk_tubes("rst", 0, 0, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_s("rst no further ejects", ej_str, "q");
    chk("rst idle after", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return controller that sits behind `vending_machine` and turns a change amount in cents into a sequence of single-coin ejector pulses drawn from three coin tubes (quarter, dime, nickel). It uses a greedy largest-coin-first algorithm against live tube counts, ejects one coin per slot with a programmable settling gap, and reports completion, shortfall and remaining tube inventory. Tube counts use the same 5-bit coin-count width as the machine's `quart`/`dim`/`nick` outputs.

## Interface

Parameters:
- `AMT_W`, 9: width of cent amounts.
- `TUBE_W`, 5: width of each tube count.
- `TUBE_MAX`, 20: tube capacity; load values above this are clamped to it.
- `GAP_CYCLES`, 1: idle cycles after each ejector pulse; must be at least 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to pay `amount`; sampled only in IDLE.
- `amount`  in  AMT_W  change owed in cents; captured with `start`.
- `load`  in  1  refill tubes; sampled only in IDLE.
- `load_q`, `load_d`, `load_n`  in  TUBE_W each  new tube counts written on `load`.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse at the end of a payout.
- `short`  out  1  payout ended with residue; valid from `done` until next accepted `start`.
- `remaining`  out  AMT_W  cents still owed.
- `eject_q`, `eject_d`, `eject_n`  out  1  one-cycle ejector pulses; at most one high per cycle.
- `quart`, `dim`, `nick`  out  TUBE_W  current tube counts.

## Operation

- Reset: state IDLE. All outputs are 0, including tube counts. `rst` overrides everything and aborts a payout in progress; no further ejects occur.
- **IDLE**
  - `load`: each tube count is set to min(`load_x`, `TUBE_MAX`).
  - `start`: `remaining` is set to `amount`, `short` is cleared, and the state goes to SELECT.
  - `load` and `start` in the same cycle: both take effect. SELECT sees the newly loaded counts.
- **SELECT**: evaluate in priority order.
  - `remaining` ≥ 25 and `quart` > 0: choose a quarter.
  - `remaining` ≥ 10 and `dim` > 0: choose a dime.
  - `remaining` ≥ 5 and `nick` > 0: choose a nickel.
  - Coin chosen: go to EJECT. On that same edge, decrement the chosen tube and subtract the coin value from `remaining`.
  - No coin chosen: go to IDLE, set `done` = 1, and set `short` = (`remaining` ≠ 0).
- **EJECT**: the matching `eject_x` is high for exactly this cycle. Next state is GAP.
- **GAP**: hold for `GAP_CYCLES` cycles using an internal counter, then return to SELECT.
- While busy, `start` and `load` are ignored. They are not queued.
- Amounts that are not a multiple of 5 pay down to the residue below 5, then end with `short` = 1 and `remaining` = residue.
- Arithmetic never underflows: a coin is chosen only if `remaining` ≥ its value and its tube is > 0.
- After `done`, `remaining` and `short` hold their values until the next accepted `start`.
- All outputs are registered or decoded from the registered state. None depends combinationally on inputs.

## Timing

- Let E0 be the edge that samples `start` in IDLE. `busy` goes high after E0.
- Each coin takes one slot of P = 2 + `GAP_CYCLES` cycles (SELECT + EJECT + GAP).
- Coin i (from 0) has its eject pulse in the cycle following edge E(1 + i·P). Tube and `remaining` updates are already visible during the pulse.
- For N coins, `done` is high in the cycle after edge E(N·P + 1). `busy` is 0 in that same cycle.
- N = 0 (amount 0, or no coin usable): `done` follows E1.
- A new `start` may be accepted in the `done` cycle, since the state is IDLE.

## Test plan

- Default parameters. Reset, load 4/4/4, start `amount`=40.
  - Pulses: `eject_q` after E1, `eject_d` after E4, `eject_n` after E7.
  - `done` after E10, with `short`=0 and `remaining`=0.
  - Final tubes 3/3/3.
- Tubes 1/4/4, `amount`=75.
  - Ejects in order: q, d, d, d, d, n, n.
  - `done` with `short`=0; final tubes 0/0/2.
- Tubes 0/0/1, `amount`=15.
  - One `eject_n`, then `done` with `short`=1 and `remaining`=10.
- `amount`=0: `done` after E1, no ejects.
- `amount`=7 with 4/4/4: one nickel, then `short`=1 and `remaining`=2.
- Pulse `start`=1 with `amount`=25 and `load`=1 with 9/9/9 mid-payout (tubes 4/4/4, `amount`=40).
  - The request and the refill are both ignored; the payout completes unchanged with final tubes 3/3/3.
  - Then from IDLE: `load` 0/2/0 together with `start` `amount`=20 pays d, d.
- `rst` asserted during an EJECT cycle.
  - Next cycle all outputs are 0 and state is IDLE.
  - No further ejects while `start` stays low.
